// File: rtl/rx_hs_entry_ctrl.sv
// C-PHY slave data-lane LP->HS entry sequencer.
// Deglitches LP state and drives the RX timer through TERM and SETTLE.
module rx_hs_entry_ctrl #(
  parameter logic [2:0] TERM_SEED   = 3'b001,
  parameter logic [2:0] SETTLE_SEED = 3'b010
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       Enable,
  input  logic [2:0] LpState,
  input  logic       Timeout,
  output logic       TimerEn,
  output logic [2:0] TimerSeed,
  output logic       TermEn,
  output logic       HsRxEn,
  output logic       ErrSot,
  output logic [2:0] StateOut
);

  typedef enum logic [2:0] {
    ST_STOP   = 3'd0,
    ST_RQST   = 3'd1,
    ST_BRIDGE = 3'd2,
    ST_TERM   = 3'd3,
    ST_HSRX   = 3'd4
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] lp_q, lp_d;
  logic [2:0] lp_acc_q, lp_acc_d;
  logic       timer_en_q, timer_en_d;
  logic       err_q, err_d;

  logic lp_stop, lp_hs0, lp_rq, tmo, timed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_STOP;
      lp_q       <= 3'b111;
      lp_acc_q   <= 3'b111;
      timer_en_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      lp_q       <= lp_d;
      lp_acc_q   <= lp_acc_d;
      timer_en_q <= timer_en_d;
      err_q      <= err_d;
    end
  end

  // accept an LP value only once it has been seen on two edges
  always_comb begin
    lp_d     = LpState;
    lp_acc_d = lp_acc_q;
    if (LpState == lp_q) lp_acc_d = LpState;
  end

  assign lp_stop = (lp_acc_q == 3'b111);
  assign lp_hs0  = (lp_acc_q == 3'b000);
  assign lp_rq   = (lp_acc_q == 3'b001);
  assign tmo     = Timeout && timer_en_q;

  always_comb begin
    state_d = state_q;
    err_d   = 1'b0;
    if (!Enable) begin
      state_d = ST_STOP;
    end else begin
      unique case (state_q)
        ST_STOP: begin
          if (lp_rq) state_d = ST_RQST;
        end
        ST_RQST: begin
          if (lp_hs0) begin
            state_d = ST_BRIDGE;
          end else if (lp_stop) begin
            state_d = ST_STOP;
          end else if (!lp_rq) begin
            state_d = ST_STOP;
            err_d   = 1'b1;
          end
        end
        ST_BRIDGE: begin
          if (lp_stop) begin
            state_d = ST_STOP;
          end else if (!lp_hs0) begin
            state_d = ST_STOP;
            err_d   = 1'b1;
          end else if (tmo) begin
            state_d = ST_TERM;
          end
        end
        ST_TERM: begin
          if (lp_stop) state_d = ST_STOP;
          else if (tmo) state_d = ST_HSRX;
        end
        ST_HSRX: begin
          if (lp_stop) state_d = ST_STOP;
        end
        default: state_d = ST_STOP;
      endcase
    end
  end

  // low on the entry cycle so the timer restarts for each phase
  assign timed      = (state_q == ST_BRIDGE) || (state_q == ST_TERM);
  assign timer_en_d = timed && (state_d == state_q);

  always_comb begin
    TimerSeed = 3'b000;
    if (state_q == ST_BRIDGE) TimerSeed = TERM_SEED;
    else if (state_q == ST_TERM) TimerSeed = SETTLE_SEED;
  end

  assign TimerEn  = timer_en_q;
  assign TermEn   = (state_q == ST_TERM) || (state_q == ST_HSRX);
  assign HsRxEn   = (state_q == ST_HSRX);
  assign ErrSot   = err_q;
  assign StateOut = state_q;

endmodule

// File: tb/tb_rx_hs_entry_ctrl.sv
// Scoreboard bench for rx_hs_entry_ctrl with an attached RX timer model.
// Expected transitions come from a dwell-count reference model.
`timescale 1ns/1ps
module tb_rx_hs_entry_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       Enable;
  logic [2:0] LpState;
  logic       Timeout;
  logic       TimerEn;
  logic [2:0] TimerSeed;
  logic       TermEn;
  logic       HsRxEn;
  logic       ErrSot;
  logic [2:0] StateOut;

  always #5 clk = ~clk;

  rx_hs_entry_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .Enable   (Enable),
    .LpState  (LpState),
    .Timeout  (Timeout),
    .TimerEn  (TimerEn),
    .TimerSeed(TimerSeed),
    .TermEn   (TermEn),
    .HsRxEn   (HsRxEn),
    .ErrSot   (ErrSot),
    .StateOut (StateOut)
  );

  // RX timer: Timeout after N+1 enabled cycles
  logic [5:0] tcnt;
  int         lim;
  logic       spur;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tcnt <= '0;
    else if (!TimerEn) tcnt <= '0;
    else if (tcnt != 6'd63) tcnt <= tcnt + 6'd1;
  end

  always_comb begin
    lim = 0;
    if (TimerSeed == 3'b001) lim = 15;
    else if (TimerSeed == 3'b010) lim = 30;
  end

  assign Timeout = (lim != 0 && int'(tcnt) >= lim + 1) ||
                   (spur && !TimerEn);

  int n_chk = 0;
  int n_err = 0;

  int         m_cyc  = 0;
  int         m_st   = 0;
  int         m_dw   = 1;
  logic [2:0] m_acc  = 3'b111;
  logic [2:0] m_prev = 3'b111;
  int         exp_code[$];
  int         exp_cyc[$];
  int         err_cyc[$];
  bit         mon_en = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d",
               nm, m_cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_st   = 0;
    m_dw   = 1;
    m_acc  = 3'b111;
    m_prev = 3'b111;
  endtask

  task automatic model_edge();
    int nst;
    bit e;
    nst = m_st;
    e   = 1'b0;
    if (!Enable) begin
      nst = 0;
    end else begin
      case (m_st)
        0: if (m_acc == 3'b001) nst = 1;
        1: begin
          if (m_acc == 3'b000) nst = 2;
          else if (m_acc == 3'b111) nst = 0;
          else if (m_acc != 3'b001) begin nst = 0; e = 1'b1; end
        end
        2: begin
          if (m_acc == 3'b111) nst = 0;
          else if (m_acc != 3'b000) begin nst = 0; e = 1'b1; end
          else if (m_dw == 18) nst = 3;
        end
        3: begin
          if (m_acc == 3'b111) nst = 0;
          else if (m_dw == 33) nst = 4;
        end
        4: if (m_acc == 3'b111) nst = 0;
        default: nst = 0;
      endcase
    end
    if (LpState == m_prev) m_acc = LpState;
    m_prev = LpState;
    if (nst != m_st) begin
      exp_code.push_back(nst);
      exp_cyc.push_back(m_cyc);
      m_dw = 1;
    end else begin
      m_dw++;
    end
    if (e) err_cyc.push_back(m_cyc);
    m_st = nst;
  endtask

  task automatic step();
    @(posedge clk);
    m_cyc++;
    if (!rst_n) model_reset();
    else model_edge();
    #1;
    spur = ($urandom_range(0, 3) == 0);
  endtask

  task automatic drive(input logic [2:0] v, input int n);
    LpState = v;
    repeat (n) step();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_state"}, int'(StateOut), 0);
    chk({tag, "_timer_en"}, int'(TimerEn), 0);
    chk({tag, "_seed"}, int'(TimerSeed), 0);
    chk({tag, "_term_en"}, int'(TermEn), 0);
    chk({tag, "_hsrx_en"}, int'(HsRxEn), 0);
    chk({tag, "_err_sot"}, int'(ErrSot), 0);
  endtask

  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    if (m_st != 0) begin
      exp_code.push_back(0);
      exp_cyc.push_back(m_cyc);
    end
    model_reset();
    #1;
    check_zero("areset");
    step();
    step();
    #2;
    rst_n = 1'b1;
  endtask

  logic [2:0] prev_st = 3'd0;
  int         pc, py;

  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (StateOut != prev_st) begin
          if (exp_code.size() == 0) begin
            chk("unexpected_transition", int'(StateOut), int'(prev_st));
          end else begin
            pc = exp_code.pop_front();
            py = exp_cyc.pop_front();
            chk("transition_state", int'(StateOut), pc);
            chk("transition_cycle", m_cyc, py);
          end
          prev_st = StateOut;
        end
        if (ErrSot) begin
          if (err_cyc.size() == 0) begin
            chk("unexpected_err_sot", 1, 0);
          end else begin
            py = err_cyc.pop_front();
            chk("err_sot_cycle", m_cyc, py);
          end
        end
        chk("term_en", int'(TermEn), int'(m_st == 3 || m_st == 4));
        chk("hsrx_en", int'(HsRxEn), int'(m_st == 4));
        chk("timer_en", int'(TimerEn),
            int'((m_st == 2 || m_st == 3) && m_dw > 1));
        chk("timer_seed", int'(TimerSeed),
            (m_st == 2) ? 1 : ((m_st == 3) ? 2 : 0));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", m_cyc);
    $fatal(1, "watchdog");
  end

  int r;

  initial begin
    rst_n   = 1'b1;
    Enable  = 1'b1;
    LpState = 3'b111;
    spur    = 1'b0;
    #2;
    rst_n = 1'b0;
    step();
    step();
    #2;
    rst_n = 1'b1;
    check_zero("reset");
    mon_en = 1'b1;

    drive(3'b111, 3);
    drive(3'b001, 5);
    drive(3'b000, 60);
    drive(3'b111, 5);

    drive(3'b001, 1);
    drive(3'b111, 4);

    drive(3'b001, 4);
    drive(3'b010, 2);
    drive(3'b111, 4);

    drive(3'b001, 4);
    drive(3'b000, 29);
    drive(3'b111, 5);

    drive(3'b001, 4);
    drive(3'b000, 8);
    Enable = 1'b0;
    drive(3'b000, 2);
    drive(3'b111, 3);
    drive(3'b001, 5);
    drive(3'b000, 60);
    Enable = 1'b1;
    drive(3'b111, 5);

    drive(3'b001, 4);
    drive(3'b000, 60);
    async_reset();
    drive(3'b111, 4);

    repeat (150) begin
      r = $urandom_range(0, 9);
      if (r < 6) begin
        drive(3'b001, $urandom_range(1, 6));
        drive(3'b000, $urandom_range(1, 60));
        if ($urandom_range(0, 2) == 0)
          drive(3'($urandom_range(0, 7)), $urandom_range(1, 3));
        drive(3'b111, $urandom_range(1, 5));
      end else if (r < 8) begin
        drive(3'($urandom_range(0, 7)), $urandom_range(1, 4));
      end else begin
        Enable = 1'b0;
        drive(3'($urandom_range(0, 7)), $urandom_range(1, 10));
        Enable = 1'b1;
        drive(3'b111, 3);
      end
    end
    drive(3'b111, 5);
    @(negedge clk);
    #1;
    chk("transitions_left", exp_code.size(), 0);
    chk("err_pulses_left", err_cyc.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/rx_hs_entry_ctrl.md
# rx_hs_entry_ctrl

Slave-side data-lane control FSM that sequences the C-PHY low-power to high-speed entry: it deglitches the synchronized LP line state, recognises Stop → HS-Request → Bridge, and drives the shared RX timer through termination-enable and settle phases before enabling the HS receiver. It sits between the LP receivers and the HS deskew/decoder. It is the only master of the lane's RX timer, so it owns `TimerEn`/`TimerSeed`.

## Interface
- `TERM_SEED`, 3'b001: timer seed for the termination-enable delay (15-cycle setting).
- `SETTLE_SEED`, 3'b010: timer seed for the HS settle delay (30-cycle setting).
- `clk` in 1: lane clock; all logic on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `Enable` in 1: lane enable. When 0, the FSM is forced to STOP.
- `LpState` in 3: LP receiver outputs {A,B,C}, already synchronized to `clk`.
- `Timeout` in 1: from the RX timer.
- `TimerEn` out 1: RX timer enable.
- `TimerSeed` out 3: RX timer seed.
- `TermEn` out 1: HS termination enable.
- `HsRxEn` out 1: HS receiver/decoder enable.
- `ErrSot` out 1: one-cycle start-of-transmission sequence error pulse.
- `StateOut` out 3: current state code (debug).

## Operation

**LP deglitch**
- `lp_q` samples `LpState` every cycle.
- `LpAcc` (accepted state) loads `LpState` only when `LpState == lp_q`, i.e. the new value was seen on 2 consecutive edges.
- All FSM decisions use `LpAcc` only.

**States and codes**
- STOP = 0: `LpAcc == 111` idle. On `LpAcc == 001` → HS_RQST. All other values: stay, no error (escape and turnaround are out of scope).
- HS_RQST = 1:
  - `LpAcc == 000` → BRIDGE.
  - `LpAcc == 111` → STOP.
  - `001`: stay.
  - Any other value: ErrSot pulse, then → STOP.
- BRIDGE = 2:
  - `TimerSeed = TERM_SEED`.
  - Qualified Timeout → TERM.
  - `LpAcc == 111` → STOP (abort).
  - `LpAcc` not in {000, 111}: ErrSot, then → STOP.
- TERM = 3:
  - `TermEn = 1`, `TimerSeed = SETTLE_SEED`.
  - Qualified Timeout → HS_RX.
  - `LpAcc == 111` → STOP.
  - Other LP values are ignored, because HS swing is present.
- HS_RX = 4:
  - `TermEn = 1`, `HsRxEn = 1`.
  - `LpAcc == 111` → STOP. This is the HS exit.
- Codes 5–7 are unreachable. If one is entered, the FSM goes to STOP on the next edge.

**Timer handling**
- `TimerEn` is a register.
- It is 0 in the first cycle of BRIDGE and of TERM, and 1 from the second cycle until the state is left. This guarantees the timer counter restarts from 0 for each phase.
- Outside BRIDGE/TERM: `TimerEn = 0`, `TimerSeed = 3'b000`.
- `TimerSeed` is constant for the whole dwell in a timed state.
- A qualified Timeout is `Timeout && TimerEn`. An unqualified Timeout is ignored.

**Enable and priority**
- `Enable = 0` → STOP on the next edge from any state. This has the highest priority; no ErrSot.
- Priority within a state: Enable low > `LpAcc == 111` abort > error > Timeout.

## Timing
- **Reset values:**
  - State STOP.
  - `lp_q = LpAcc = 3'b111`.
  - `TimerEn = 0`, `TimerSeed = 0`, `TermEn = 0`, `HsRxEn = 0`, `ErrSot = 0`, `StateOut = 0`.
- **Reset mid-operation:** all of the above take effect immediately; the timer is released by `TimerEn = 0`.
- **Output timing:** `TermEn`, `HsRxEn` and `StateOut` are decoded from the state register, with no combinational path from inputs.
- **ErrSot:** high exactly in the first STOP cycle following the error.
- **LP latency:** a stable `LpState` change before edge k gives `LpAcc` updated after edge k+1 and the state changed after edge k+2.
  - A 1-cycle glitch never changes `LpAcc`.
- **Timer contract:** the timer asserts Timeout in the cycle after N+1 enabled cycles (N = seed time).
- **BRIDGE dwell** = 1 (TimerEn low) + N+1 + 1 (Timeout seen) = N+3 cycles. With the 15-cycle seed this is 18 cycles.
- **TERM dwell** = 33 cycles with the 30-cycle seed.
- **Abort during a timed state:** `TimerEn` drops on the same edge the state changes. A Timeout arriving in the same cycle as `LpAcc == 111` is ignored, and the FSM goes to STOP.

## Test plan
- **Nominal entry:** reset, then `LpState` 111 → 001 (held 5 cycles) → 000, with RxTimer attached.
  - Required: BRIDGE for 18 cycles with `TimerEn` low in its first cycle.
  - Required: TERM (`TermEn = 1`) for 33 cycles.
  - Required: HS_RX with `HsRxEn = 1`.
  - Then `LpState = 111` → STOP 2 cycles after the LP change, with `TermEn = HsRxEn = 0`.
- **Glitch rejection:** in STOP, `LpState = 001` for 1 cycle then back to 111 → `LpAcc` stays 111, state stays 0.
- **Sequence error:** in HS_RQST, `LpState = 010` for 2 cycles → one ErrSot pulse coincident with STOP entry; `StateOut = 0`.
- **Abort in TERM:** `LpState = 111` at cycle 10 of TERM → STOP, `TimerEn = 0`, `TermEn = 0`, no ErrSot, `HsRxEn` never asserted.
- **Enable drop:** `Enable = 0` during BRIDGE → STOP on the next edge, `TimerEn = 0`.
  - With Enable held low and the full LP sequence applied, the state stays 0.
- **Async reset:** assert `rst_n` mid-HS_RX, off a clock edge → all outputs 0 and `StateOut = 0` immediately.
